// File: rtl/div_sqrt_postprocess.sv
// rtl/div_sqrt_postprocess.sv - div/sqrt back end: normalize, round, resolve specials, pack IEEE-754 result
module div_sqrt_postprocess #(
    parameter int C_EXP  = 8,
    parameter int C_MANT = 23
) (
    input  logic                  Clk_CI,
    input  logic                  Rst_RBI,
    input  logic                  Valid_SI,
    output logic                  Ready_SO,
    input  logic                  Div_op_SI,
    input  logic [C_MANT+2:0]     Mant_res_DI,
    input  logic                  Sticky_SI,
    input  logic [C_EXP+1:0]      Exp_res_DI,
    input  logic                  Sign_z_DI,
    input  logic [1:0]            RM_SI,
    input  logic                  Zero_a_SI,
    input  logic                  Zero_b_SI,
    input  logic                  Inf_a_SI,
    input  logic                  Inf_b_SI,
    input  logic                  NaN_a_SI,
    input  logic                  NaN_b_SI,
    input  logic                  SNaN_SI,
    output logic                  Valid_SO,
    input  logic                  Ready_SI,
    output logic [C_EXP+C_MANT:0] Result_DO,
    output logic [4:0]            Fflags_SO
);

    localparam int C_OP = 1 + C_EXP + C_MANT;
    localparam int EW   = C_EXP + 2;
    localparam int SW   = C_MANT + 2;
    localparam int SHW  = $clog2(SW + 1);

    localparam logic signed [EW-1:0] ZERO_E   = '0;
    localparam logic signed [EW-1:0] ONE_E    = EW'(1);
    localparam logic signed [EW-1:0] EMAX     = EW'(2**C_EXP - 1);
    localparam logic signed [EW-1:0] EMAX_M1  = EW'(2**C_EXP - 2);
    localparam logic signed [EW-1:0] ESAT     = EW'(2**(EW-1) - 1);
    localparam logic signed [EW-1:0] TINY_SAT = EW'(1 - SW);

    localparam logic [C_OP-1:0] QNAN = {1'b0, {C_EXP{1'b1}}, 1'b1, {(C_MANT-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, NORM, ROUND, DONE} state_t;
    state_t state_q, state_d;

    logic                 div_q, sticky_q, sign_q, snan_q;
    logic                 za_q, zb_q, ia_q, ib_q, na_q, nb_q;
    logic [C_MANT+2:0]    mant_q;
    logic signed [EW-1:0] exp_q;
    logic [1:0]           rm_q;

    logic [SW-1:0]        sig_r;
    logic                 st_r, tiny_r;
    logic signed [EW-1:0] exp_r;

    logic [C_OP-1:0]      result_q;
    logic [4:0]           fflags_q;

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (Valid_SI) state_d = NORM;
            NORM:    state_d = ROUND;
            ROUND:   state_d = DONE;
            DONE:    if (Ready_SI) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign Ready_SO  = (state_q == IDLE);
    assign Valid_SO  = (state_q == DONE);
    assign Result_DO = result_q;
    assign Fflags_SO = fflags_q;

    // Normalization: fold a 2^1 overflow bit back, then denormalize tiny results
    logic [SW-1:0]        sig_a, sig_n;
    logic                 st_a, st_n, tiny_n;
    logic signed [EW-1:0] exp_a, exp_n;
    logic [SHW-1:0]       sh;
    logic [2*SW-1:0]      wide;

    always_comb begin
        if (mant_q[C_MANT+2]) begin
            sig_a = mant_q[C_MANT+2:1];
            st_a  = sticky_q | mant_q[0];
            exp_a = (exp_q == ESAT) ? exp_q : exp_q + ONE_E;
        end else begin
            sig_a = mant_q[SW-1:0];
            st_a  = sticky_q;
            exp_a = exp_q;
        end
        tiny_n = (exp_a <= ZERO_E);
        sh     = (exp_a < TINY_SAT) ? SHW'(SW) : SHW'(ONE_E - exp_a);
        wide   = {sig_a, {SW{1'b0}}} >> sh;
        sig_n  = sig_a;
        st_n   = st_a;
        exp_n  = exp_a;
        if (tiny_n) begin
            sig_n = wide[2*SW-1:SW];
            st_n  = st_a | (|wide[SW-1:0]);
            exp_n = ZERO_E;
        end
    end

    // Rounding and overflow handling on the registered normalized significand
    logic                 g, l, inc, nx, carry, of, uf, to_inf;
    logic [SW-1:0]        rnd;
    logic [C_EXP-1:0]     exp_fin;
    logic [C_OP-1:0]      round_res;
    logic [4:0]           round_flg;

    always_comb begin
        g = sig_r[0];
        l = sig_r[1];
        case (rm_q)
            2'b00:   inc = g & (st_r | l);
            2'b01:   inc = 1'b0;
            2'b10:   inc = (g | st_r) & sign_q;
            default: inc = (g | st_r) & ~sign_q;
        endcase
        nx      = g | st_r;
        rnd     = {1'b0, sig_r[SW-1:1]} + SW'(inc);
        carry   = rnd[SW-1];
        exp_fin = tiny_r ? C_EXP'(rnd[C_MANT]) : exp_r[C_EXP-1:0] + C_EXP'(carry);
        of      = ~tiny_r & ((exp_r >= EMAX) | (carry & (exp_r == EMAX_M1)));
        uf      = tiny_r & nx;
        to_inf  = (rm_q == 2'b00) | ((rm_q == 2'b10) & ~sign_q) | ((rm_q == 2'b11) & sign_q);
        round_res = {sign_q, exp_fin, rnd[C_MANT-1:0]};
        round_flg = {2'b00, 1'b0, uf, nx};
        if (of) begin
            round_res = to_inf ? {sign_q, {C_EXP{1'b1}}, {C_MANT{1'b0}}}
                               : {sign_q, {(C_EXP-1){1'b1}}, 1'b0, {C_MANT{1'b1}}};
            round_flg = 5'b00101;
        end
    end

    logic            special, spec_nv, spec_dz;
    logic [C_OP-1:0] spec_res;

    always_comb begin
        special  = 1'b1;
        spec_nv  = snan_q;
        spec_dz  = 1'b0;
        spec_res = QNAN;
        if (div_q) begin
            if (na_q | nb_q)                        spec_res = QNAN;
            else if ((za_q & zb_q) | (ia_q & ib_q)) spec_nv  = 1'b1;
            else if (ia_q)                          spec_res = {sign_q, {C_EXP{1'b1}}, {C_MANT{1'b0}}};
            else if (zb_q) begin
                spec_res = {sign_q, {C_EXP{1'b1}}, {C_MANT{1'b0}}};
                spec_dz  = 1'b1;
            end
            else if (ib_q | za_q)                   spec_res = {sign_q, {(C_OP-1){1'b0}}};
            else                                    special  = 1'b0;
        end else begin
            if (na_q)                  spec_res = QNAN;
            else if (sign_q & ~za_q)   spec_nv  = 1'b1;
            else if (za_q)             spec_res = {sign_q, {(C_OP-1){1'b0}}};
            else if (ia_q)             spec_res = {sign_q, {C_EXP{1'b1}}, {C_MANT{1'b0}}};
            else                       special  = 1'b0;
        end
    end

    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
        if (!Rst_RBI) begin
            div_q <= 1'b0; sticky_q <= 1'b0; sign_q <= 1'b0; snan_q <= 1'b0;
            za_q  <= 1'b0; zb_q <= 1'b0; ia_q <= 1'b0; ib_q <= 1'b0;
            na_q  <= 1'b0; nb_q <= 1'b0;
            mant_q <= '0; exp_q <= '0; rm_q <= 2'b00;
            sig_r <= '0; st_r <= 1'b0; tiny_r <= 1'b0; exp_r <= '0;
            result_q <= '0; fflags_q <= '0;
        end else begin
            if (state_q == IDLE && Valid_SI) begin
                div_q <= Div_op_SI; mant_q <= Mant_res_DI; sticky_q <= Sticky_SI;
                exp_q <= Exp_res_DI; sign_q <= Sign_z_DI; rm_q <= RM_SI;
                za_q  <= Zero_a_SI; zb_q <= Zero_b_SI; ia_q <= Inf_a_SI; ib_q <= Inf_b_SI;
                na_q  <= NaN_a_SI; nb_q <= NaN_b_SI; snan_q <= SNaN_SI;
            end
            if (state_q == NORM) begin
                sig_r <= sig_n; st_r <= st_n; tiny_r <= tiny_n; exp_r <= exp_n;
            end
            if (state_q == ROUND) begin
                result_q <= special ? spec_res : round_res;
                fflags_q <= special ? {spec_nv, spec_dz, 3'b000} : round_flg;
            end
        end
    end

endmodule

// File: tb/tb_div_sqrt_postprocess.sv
// tb/tb_div_sqrt_postprocess.sv - vector table plus handshake/reset sequences with a result scoreboard
module tb_div_sqrt_postprocess;

    logic        Clk_CI = 1'b0;
    logic        Rst_RBI = 1'b0;
    logic        Valid_SI = 1'b0, Ready_SO, Div_op_SI = 1'b0, Sticky_SI = 1'b0, Sign_z_DI = 1'b0;
    logic [25:0] Mant_res_DI = '0;
    logic [9:0]  Exp_res_DI = '0;
    logic [1:0]  RM_SI = 2'b00;
    logic        Zero_a_SI = 1'b0, Zero_b_SI = 1'b0, Inf_a_SI = 1'b0, Inf_b_SI = 1'b0;
    logic        NaN_a_SI = 1'b0, NaN_b_SI = 1'b0, SNaN_SI = 1'b0;
    logic        Valid_SO, Ready_SI = 1'b1;
    logic [31:0] Result_DO;
    logic [4:0]  Fflags_SO;

    div_sqrt_postprocess dut (
        .Clk_CI(Clk_CI), .Rst_RBI(Rst_RBI), .Valid_SI(Valid_SI), .Ready_SO(Ready_SO),
        .Div_op_SI(Div_op_SI), .Mant_res_DI(Mant_res_DI), .Sticky_SI(Sticky_SI),
        .Exp_res_DI(Exp_res_DI), .Sign_z_DI(Sign_z_DI), .RM_SI(RM_SI),
        .Zero_a_SI(Zero_a_SI), .Zero_b_SI(Zero_b_SI), .Inf_a_SI(Inf_a_SI), .Inf_b_SI(Inf_b_SI),
        .NaN_a_SI(NaN_a_SI), .NaN_b_SI(NaN_b_SI), .SNaN_SI(SNaN_SI),
        .Valid_SO(Valid_SO), .Ready_SI(Ready_SI), .Result_DO(Result_DO), .Fflags_SO(Fflags_SO)
    );

    always #5 Clk_CI = ~Clk_CI;

    typedef struct {
        string       name;
        logic        div;
        logic [25:0] mant;
        logic        sticky;
        logic [9:0]  exp;
        logic        sign;
        logic [1:0]  rm;
        logic [6:0]  cls;   // {za, zb, ia, ib, na, nb, snan}
        logic [31:0] res;
        logic [4:0]  flg;
    } vec_t;

    vec_t        vecs[$];
    logic [31:0] sb_res[$];
    logic [4:0]  sb_flg[$];
    int          errors = 0;
    int          checks = 0;

    function automatic vec_t mk(string n, logic d, logic [25:0] m, logic st, logic [9:0] e,
                                logic sg, logic [1:0] rm, logic [6:0] c, logic [31:0] r, logic [4:0] f);
        vec_t v;
        v.name = n; v.div = d; v.mant = m; v.sticky = st; v.exp = e; v.sign = sg;
        v.rm = rm; v.cls = c; v.res = r; v.flg = f;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        Div_op_SI = v.div; Mant_res_DI = v.mant; Sticky_SI = v.sticky; Exp_res_DI = v.exp;
        Sign_z_DI = v.sign; RM_SI = v.rm;
        {Zero_a_SI, Zero_b_SI, Inf_a_SI, Inf_b_SI, NaN_a_SI, NaN_b_SI, SNaN_SI} = v.cls;
    endtask

    task automatic pop_compare(input string nm);
        logic [31:0] er;
        logic [4:0]  ef;
        if (sb_res.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: unexpected Valid_SO with empty scoreboard", nm);
        end else begin
            er = sb_res.pop_front();
            ef = sb_flg.pop_front();
            check({nm, " result"}, Result_DO, er);
            check({nm, " flags"}, 32'(Fflags_SO), 32'(ef));
        end
    endtask

    // Accept on one edge, then count edges until Valid_SO; the accept edge is edge 1
    task automatic launch_and_wait(input vec_t v);
        int cyc;
        drive(v);
        Valid_SI = 1'b1;
        sb_res.push_back(v.res);
        sb_flg.push_back(v.flg);
        @(posedge Clk_CI); #1;
        Valid_SI = 1'b0;
        cyc = 1;
        while (!Valid_SO && cyc < 20) begin
            @(posedge Clk_CI); #1;
            cyc++;
        end
        check({v.name, " latency"}, 32'(cyc), 32'd3);
        if (Valid_SO) pop_compare(v.name);
    endtask

    initial begin
        vec_t v, other;
        int   seen;

        vecs.push_back(mk("div1.5",      1, 26'h1800000, 0, 10'd127, 0, 2'b00, 7'b0, 32'h3FC00000, 5'b00000));
        vecs.push_back(mk("msb_set",     1, 26'h2000000, 0, 10'd127, 0, 2'b00, 7'b0, 32'h40000000, 5'b00000));
        vecs.push_back(mk("tie_rne",     1, 26'h1000001, 0, 10'd127, 0, 2'b00, 7'b0, 32'h3F800000, 5'b00001));
        vecs.push_back(mk("tie_rup",     1, 26'h1000001, 0, 10'd127, 0, 2'b11, 7'b0, 32'h3F800001, 5'b00001));
        vecs.push_back(mk("tie_rdn_pos", 1, 26'h1000001, 0, 10'd127, 0, 2'b10, 7'b0, 32'h3F800000, 5'b00001));
        vecs.push_back(mk("tie_rdn_neg", 1, 26'h1000001, 0, 10'd127, 1, 2'b10, 7'b0, 32'hBF800001, 5'b00001));
        vecs.push_back(mk("tie_rne_odd", 1, 26'h1000003, 0, 10'd127, 0, 2'b00, 7'b0, 32'h3F800002, 5'b00001));
        vecs.push_back(mk("round_carry", 1, 26'h1FFFFFF, 0, 10'd127, 0, 2'b00, 7'b0, 32'h40000000, 5'b00001));
        vecs.push_back(mk("ovf_rne",     1, 26'h1000000, 0, 10'd255, 0, 2'b00, 7'b0, 32'h7F800000, 5'b00101));
        vecs.push_back(mk("ovf_rtz",     1, 26'h1000000, 0, 10'd255, 0, 2'b01, 7'b0, 32'h7F7FFFFF, 5'b00101));
        vecs.push_back(mk("ovf_carry",   1, 26'h1FFFFFF, 0, 10'd254, 0, 2'b00, 7'b0, 32'h7F800000, 5'b00101));
        vecs.push_back(mk("subnorm",     1, 26'h1000000, 0, 10'h3FF, 0, 2'b00, 7'b0, 32'h00200000, 5'b00000));
        vecs.push_back(mk("subnorm_st",  1, 26'h1000000, 1, 10'h3FF, 0, 2'b00, 7'b0, 32'h00200000, 5'b00011));
        vecs.push_back(mk("sub_to_norm", 1, 26'h1FFFFFF, 0, 10'd0,   0, 2'b00, 7'b0, 32'h00800000, 5'b00011));
        vecs.push_back(mk("deep_rne",    1, 26'h1000000, 0, 10'h39C, 0, 2'b00, 7'b0, 32'h00000000, 5'b00011));
        vecs.push_back(mk("deep_rup",    1, 26'h1000000, 0, 10'h39C, 0, 2'b11, 7'b0, 32'h00000001, 5'b00011));
        vecs.push_back(mk("div_0_0",     1, 26'h0, 0, 10'd0,   0, 2'b00, 7'b1100000, 32'h7FC00000, 5'b10000));
        vecs.push_back(mk("div_1_0",     1, 26'h1000000, 0, 10'd127, 0, 2'b00, 7'b0100000, 32'h7F800000, 5'b01000));
        vecs.push_back(mk("div_inf_inf", 1, 26'h0, 0, 10'd0,   0, 2'b00, 7'b0011000, 32'h7FC00000, 5'b10000));
        vecs.push_back(mk("div_snan",    1, 26'h0, 0, 10'd0,   0, 2'b00, 7'b0000101, 32'h7FC00000, 5'b10000));
        vecs.push_back(mk("div_qnan",    1, 26'h0, 0, 10'd0,   0, 2'b00, 7'b0000010, 32'h7FC00000, 5'b00000));
        vecs.push_back(mk("div_ninf_x",  1, 26'h0, 0, 10'd0,   1, 2'b00, 7'b0010000, 32'hFF800000, 5'b00000));
        vecs.push_back(mk("div_inf_0",   1, 26'h0, 0, 10'd0,   0, 2'b00, 7'b0110000, 32'h7F800000, 5'b00000));
        vecs.push_back(mk("div_n0_x",    1, 26'h0, 0, 10'd0,   1, 2'b00, 7'b1000000, 32'h80000000, 5'b00000));
        vecs.push_back(mk("sqrt_neg4",   0, 26'h1000000, 0, 10'd129, 1, 2'b00, 7'b0, 32'h7FC00000, 5'b10000));
        vecs.push_back(mk("sqrt_neg0",   0, 26'h0, 0, 10'd0,   1, 2'b00, 7'b1000000, 32'h80000000, 5'b00000));
        vecs.push_back(mk("sqrt_pinf",   0, 26'h0, 0, 10'd0,   0, 2'b00, 7'b0010000, 32'h7F800000, 5'b00000));
        vecs.push_back(mk("sqrt_ninf",   0, 26'h0, 0, 10'd0,   1, 2'b00, 7'b0010000, 32'h7FC00000, 5'b10000));

        repeat (3) @(posedge Clk_CI);
        #1;
        check("reset Valid_SO", 32'(Valid_SO), 32'd0);
        check("reset Ready_SO", 32'(Ready_SO), 32'd1);
        check("reset Result_DO", Result_DO, 32'h0);
        check("reset Fflags_SO", 32'(Fflags_SO), 32'd0);
        @(negedge Clk_CI);
        Rst_RBI = 1'b1;
        @(posedge Clk_CI); #1;

        for (int i = 0; i < vecs.size(); i++) begin
            launch_and_wait(vecs[i]);
            @(posedge Clk_CI); #1;
            check({vecs[i].name, " back to idle"}, 32'(Ready_SO), 32'd1);
        end

        // Back-pressure: output must hold while new Valid_SI requests are ignored
        v     = vecs[3];
        other = vecs[17];
        Ready_SI = 1'b0;
        launch_and_wait(v);
        for (int k = 0; k < 5; k++) begin
            drive(other);
            Valid_SI = 1'b1;
            @(posedge Clk_CI); #1;
            check("bp hold result", Result_DO, v.res);
            check("bp hold flags", 32'(Fflags_SO), 32'(v.flg));
            check("bp hold valid", 32'(Valid_SO), 32'd1);
            check("bp ready low", 32'(Ready_SO), 32'd0);
        end
        Valid_SI = 1'b0;
        Ready_SI = 1'b1;
        @(posedge Clk_CI); #1;
        check("bp release valid", 32'(Valid_SO), 32'd0);
        seen = 0;
        repeat (6) begin
            @(posedge Clk_CI); #1;
            if (Valid_SO) seen++;
        end
        check("bp ignored inputs", 32'(seen), 32'd0);

        // Reset asserted while in ROUND discards the in-flight result
        drive(vecs[0]);
        Valid_SI = 1'b1;
        @(posedge Clk_CI); #1;
        Valid_SI = 1'b0;
        @(posedge Clk_CI); #1;
        Rst_RBI = 1'b0;
        #1;
        check("rst mid valid", 32'(Valid_SO), 32'd0);
        check("rst mid ready", 32'(Ready_SO), 32'd1);
        check("rst mid result", Result_DO, 32'h0);
        check("rst mid flags", 32'(Fflags_SO), 32'd0);
        @(negedge Clk_CI);
        Rst_RBI = 1'b1;
        seen = 0;
        repeat (8) begin
            @(posedge Clk_CI); #1;
            if (Valid_SO) seen++;
        end
        check("rst no valid", 32'(seen), 32'd0);

        launch_and_wait(vecs[1]);
        @(posedge Clk_CI); #1;
        check("scoreboard drained", 32'(sb_res.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
